blink_meter: RTL and testbench

Measures the square wave on a single LED-style signal, such as a blinker output or a looped-back GPIO. It reports the period and high time of each full cycle through a valid/ready result interface. It is the receive side of the blinker: a self-check block for on-board loopback and for test benches that confirm blink rates without a scope.

---
 rtl/blink_meter.sv | 196 +++++++++++++++++++
 tb/tb_blink_meter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blink_meter.sv
// -----------------------------------------------------------------------------
// blink_meter
//
// Measures a square wave on a single LED-style signal, such as a blinker output
// or a looped-back GPIO. For every full cycle of the input it reports the
// period and the high time, both in clock cycles, through a valid/ready result
// interface. It is the receive-side self-check for a blinker.
//
// Parameters:
//   CNT_W        width of the period / high-time counters and outputs
//   SYNC_STAGES  number of input synchronizer flops (2 or more)
//
// Ports:
//   clk        in   single clock
//   rst_n      in   asynchronous, active-low reset
//   blink_in   in   asynchronous signal to be measured
//   period     out  cycles between two consecutive accepted rising edges
//   high_time  out  cycles the (filtered) input was high within that period
//   valid      out  result presented; held until accepted
//   ready      in   consumer takes the result on a cycle with valid & ready
//   dropped    out  sticky: a completed measurement was discarded because the
//                   previous result was still being held; cleared by reset
//   timeout    out  one-cycle pulse when no rising edge arrives within
//                   2^CNT_W-1 cycles while measuring
//
// Build option:
//   BLINK_METER_GLITCH_FILTER_EN  when defined, a 3-cycle stability filter sits
//   between the synchronizer and the edge detector, so pulses of 1-2 cycles
//   are ignored. When undefined, every synchronized transition is measured.
// -----------------------------------------------------------------------------
module blink_meter #(
    parameter int CNT_W       = 27,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             blink_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    input  logic             ready,
    output logic             dropped,
    output logic             timeout
);

    // Last count value from which a further increment would reach 2^CNT_W-1.
    // Reaching that value without a rising edge ends the measurement.
    localparam logic [CNT_W-1:0] CNT_PRE_MAX = {{(CNT_W-1){1'b1}}, 1'b0};

    typedef enum logic {
        ARM  = 1'b0,
        MEAS = 1'b1
    } state_t;

    // Saturating increment: the timeout always fires before a counter could
    // wrap, so saturation is only a safety net that keeps high_time <= period.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val,
                                                 input logic             inc);
        logic [CNT_W-1:0] res;
        res = val;
        if (inc && (val != {CNT_W{1'b1}})) begin
            res = val + CNT_W'(1);
        end
        return res;
    endfunction

    // ---- stage p0: input synchronizer ---------------------------------------
    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   sync_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], blink_in};
        end
    end

    assign sync_out = sync_p0[SYNC_STAGES-1];

    // ---- stage p1: optional stability filter --------------------------------
    logic s;

`ifdef BLINK_METER_GLITCH_FILTER_EN
    logic [1:0] hist_p1;
    logic       filt_p1;

    // The filtered level follows the synchronized input only once the current
    // sample and the two previous ones agree, i.e. after 3 stable cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_p1 <= '0;
            filt_p1 <= 1'b0;
        end else begin
            hist_p1 <= {hist_p1[0], sync_out};
            if (sync_out && hist_p1[0] && hist_p1[1]) begin
                filt_p1 <= 1'b1;
            end else if (!sync_out && !hist_p1[0] && !hist_p1[1]) begin
                filt_p1 <= 1'b0;
            end
        end
    end

    assign s = filt_p1;
`else
    assign s = sync_out;
`endif

    // ---- stage p2: edge detection -------------------------------------------
    logic s_d;
    logic rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_d <= 1'b0;
        end else begin
            s_d <= s;
        end
    end

    assign rise = s & ~s_d;

    // ---- stage p3: measurement FSM and result handoff -----------------------
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hcnt;
    logic             cand;
    logic [CNT_W-1:0] cand_period;
    logic [CNT_W-1:0] cand_high;

    // A candidate result exists on every rising edge seen while measuring.
    // The high counter samples the delayed level s_d, so the high sample of
    // the cycle that carried the opening edge lands in this period and the
    // sample of the cycle just before the closing edge is added here.
    always_comb begin
        cand        = (state == MEAS) && rise;
        cand_period = sat_inc(cnt, 1'b1);
        cand_high   = sat_inc(hcnt, s_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARM;
            cnt       <= '0;
            hcnt      <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            dropped   <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            timeout <= 1'b0;

            case (state)
                ARM: begin
                    if (rise) begin
                        cnt   <= '0;
                        hcnt  <= '0;
                        state <= MEAS;
                    end
                end
                MEAS: begin
                    if (rise) begin
                        // The edge that closes one period opens the next.
                        cnt  <= '0;
                        hcnt <= '0;
                    end else if (cnt == CNT_PRE_MAX) begin
                        timeout <= 1'b1;
                        state   <= ARM;
                    end else begin
                        cnt  <= sat_inc(cnt, 1'b1);
                        hcnt <= sat_inc(hcnt, s_d);
                    end
                end
                default: begin
                    state <= ARM;
                end
            endcase

            // A candidate may load on the same cycle the held result is
            // accepted; otherwise a held result wins and the candidate is lost.
            if (cand) begin
                if (!valid || ready) begin
                    period    <= cand_period;
                    high_time <= cand_high;
                    valid     <= 1'b1;
                end else begin
                    dropped <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_blink_meter.sv
`timescale 1ns/1ps
module tb_blink_meter;

    localparam int CNT_W       = 8;
    localparam int SYNC_STAGES = 2;

`ifdef BLINK_METER_GLITCH_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b1;
    logic             blink_in = 1'b0;
    logic             ready    = 1'b0;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             valid;
    logic             dropped;
    logic             timeout;

    blink_meter #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .blink_in (blink_in),
        .period   (period),
        .high_time(high_time),
        .valid    (valid),
        .ready    (ready),
        .dropped  (dropped),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hi;
        int lo;
        int ep;
        int eh;
        bit sh;   // wave has a phase shorter than 3 cycles
    } vec_t;

    vec_t tbl[9];

    int errors = 0;
    int checks = 0;
    int exp_p[$];
    int exp_h[$];
    int cyc = 0;
    int tout_cnt = 0;
    int tout_last = 0;
    int valid_hi_cnt = 0;

    function automatic void check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    task automatic expect_res(input int p, input int h);
        exp_p.push_back(p);
        exp_h.push_back(h);
    endtask

    // Observes the DUT mid-cycle and scores every accepted result.
    task automatic monitor();
        int p;
        int h;
        cyc++;
        if (timeout) begin
            tout_cnt++;
            tout_last = cyc;
        end
        if (rst_n && valid) valid_hi_cnt++;
        if (rst_n && valid && ready) begin
            if (exp_p.size() == 0) begin
                check("unexpected_result_queue", exp_p.size(), 1);
            end else begin
                p = exp_p.pop_front();
                h = exp_h.pop_front();
                check("period", int'(period), p);
                check("high_time", int'(high_time), h);
                check("high_le_period", int'(high_time <= period), 1);
            end
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            monitor();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wave(input int hi, input int lo);
        blink_in = 1'b1;
        step(hi);
        blink_in = 1'b0;
        step(lo);
    endtask

    task automatic do_reset();
        blink_in = 1'b0;
        ready    = 1'b1;
        rst_n    = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int prev_p;
        int prev_h;
        bit have_prev;
        int n_res;
        int v0;
        int t0;
        int base;

        tbl[0] = '{4,   6,  10,   4, 1'b0};
        tbl[1] = '{1,   1,   2,   1, 1'b1};
        tbl[2] = '{2,   1,   3,   2, 1'b1};
        tbl[3] = '{1,   9,  10,   1, 1'b1};
        tbl[4] = '{7,   3,  10,   7, 1'b0};
        tbl[5] = '{3,   3,   6,   3, 1'b0};
        tbl[6] = '{20,  30, 50,  20, 1'b0};
        tbl[7] = '{200, 55, 255, 200, 1'b0};
        tbl[8] = '{5,   4,   9,   5, 1'b0};

        // ---------------- reset values ----------------
        #1 rst_n = 1'b0;
        step(2);
        check("rst_period", int'(period), 0);
        check("rst_high_time", int'(high_time), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_dropped", int'(dropped), 0);
        check("rst_timeout", int'(timeout), 0);
        rst_n = 1'b1;
        ready = 1'b1;
        step(3);
        check("post_rst_valid", int'(valid), 0);

        // ---------------- table-driven waves, ready held high ----------------
        have_prev = 1'b0;
        n_res = 0;
        v0 = valid_hi_cnt;
        for (int i = 0; i < 9; i++) begin
            if (FILT && tbl[i].sh) continue;
            for (int k = 0; k < 3; k++) begin
                if (have_prev) begin
                    expect_res(prev_p, prev_h);
                    n_res++;
                end
                wave(tbl[i].hi, tbl[i].lo);
                have_prev = 1'b1;
                prev_p = tbl[i].ep;
                prev_h = tbl[i].eh;
            end
        end
        expect_res(prev_p, prev_h);
        n_res++;
        blink_in = 1'b1;
        step(3);
        blink_in = 1'b0;
        step(8);
        check("table_queue_drained", exp_p.size(), 0);
        check("table_valid_once_per_period", valid_hi_cnt - v0, n_res);
        check("table_no_timeout", tout_cnt, 0);
        check("table_no_drop", int'(dropped), 0);

        // ---------------- reset mid-measurement ----------------
        do_reset();
        wave(4, 6);
        expect_res(10, 4);
        wave(4, 6);
        expect_res(10, 4);
        blink_in = 1'b1;
        step(4);
        blink_in = 1'b0;
        step(2);
        rst_n = 1'b0;
        #1;
        check("midrst_period", int'(period), 0);
        check("midrst_high_time", int'(high_time), 0);
        check("midrst_valid", int'(valid), 0);
        check("midrst_timeout", int'(timeout), 0);
        step(1);
        rst_n = 1'b1;
        step(4);
        wave(4, 6);          // arming rise only
        expect_res(10, 4);
        wave(4, 6);
        expect_res(10, 4);
        blink_in = 1'b1;
        step(4);
        blink_in = 1'b0;
        step(6);
        check("midrst_queue_drained", exp_p.size(), 0);

        // ---------------- backpressure ----------------
        do_reset();
        ready = 1'b0;
        wave(4, 6);
        expect_res(10, 4);   // held; the next two candidates are dropped
        wave(4, 6);
        wave(4, 6);
        wave(4, 6);
        check("bp_dropped", int'(dropped), 1);
        check("bp_valid_held", int'(valid), 1);
        check("bp_period_held", int'(period), 10);
        check("bp_high_held", int'(high_time), 4);
        ready = 1'b1;
        step(1);
        ready = 1'b0;
        step(1);
        check("bp_valid_fell", int'(valid), 0);
        check("bp_dropped_sticky", int'(dropped), 1);
        expect_res(12, 4);   // period stretched by the two extra low cycles
        wave(4, 6);
        check("bp_new_valid", int'(valid), 1);
        ready = 1'b1;
        step(2);
        check("bp_queue_drained", exp_p.size(), 0);

        // ---------------- accept and load on the same cycle ----------------
        do_reset();
        ready = 1'b0;
        wave(4, 6);
        expect_res(10, 4);
        wave(5, 7);
        expect_res(12, 5);
        blink_in = 1'b1;
        step(2);             // rise reaches the FSM on the next edge
        ready = 1'b1;
        step(1);
        ready = 1'b0;
        check("same_valid_kept", int'(valid), 1);
        check("same_period_new", int'(period), 12);
        check("same_high_new", int'(high_time), 5);
        check("same_no_drop", int'(dropped), 0);
        step(2);
        blink_in = 1'b0;
        step(7);
        ready = 1'b1;
        step(2);
        check("same_queue_drained", exp_p.size(), 0);

        // ---------------- timeout ----------------
        do_reset();
        t0 = tout_cnt;
        v0 = valid_hi_cnt;
        blink_in = 1'b1;
        base = cyc;
        step(4);
        blink_in = 1'b0;
        step(296);
        check("timeout_count", tout_cnt - t0, 1);
        // Rise enters the FSM on the 3rd edge after the drive (2 sync flops +
        // edge register); timeout is visible 255 edges later, scored at the
        // following mid-cycle sample.
        check("timeout_cycle", tout_last - base, 259);
        check("timeout_no_valid", valid_hi_cnt - v0, 0);
        wave(4, 6);          // re-arm
        expect_res(10, 4);
        wave(4, 6);
        check("timeout_rearm_drained", exp_p.size(), 0);

        // ---------------- glitch in the low phase ----------------
        do_reset();
        wave(4, 6);
        expect_res(10, 4);
        blink_in = 1'b1;
        step(4);
        blink_in = 1'b0;
        step(3);
`ifndef BLINK_METER_GLITCH_FILTER_EN
        expect_res(7, 4);
`endif
        blink_in = 1'b1;
        step(1);
        blink_in = 1'b0;
        step(2);
`ifdef BLINK_METER_GLITCH_FILTER_EN
        expect_res(10, 4);
`else
        expect_res(3, 1);
`endif
        wave(4, 6);
        check("glitch_queue_drained", exp_p.size(), 0);

        check("final_queue_empty", exp_p.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
